// File: rtl/brcomp_iter.sv
// Iterative branch comparator: resolves the RV32I branch conditions by comparing
// CHUNK-bit slices MSB-first and stopping at the first differing slice.
module brcomp_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic             br_unsigned,
  input  logic [2:0]       br_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             br_less,
  output logic             br_equal,
  output logic             br_taken,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("brcomp_iter: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             less_q, less_d;
  logic             equal_q, equal_d;
  logic             taken_q, taken_d;
  logic             busy_q, busy_d;

  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CHUNK-1:0] a_chunk, b_chunk;
  logic [WIDTH-1:0] sign_flip;
  logic             accept;

  function automatic logic taken_f(input logic [2:0] op, input logic less, input logic equal);
    logic t;
    case (op)
      3'b000:         t = equal;
      3'b001:         t = ~equal;
      3'b100, 3'b110: t = less;
      3'b101, 3'b111: t = ~less;
      default:        t = 1'b0;
    endcase
    return t;
  endfunction

  assign req_ready = i_rst_n & (state_q == IDLE) & ~flush;
  assign accept    = req_valid & req_ready;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  assign sign_flip = {~br_unsigned, {(WIDTH-1){1'b0}}};

  assign a_sh    = a_q >> (int'(idx_q) * CHUNK);
  assign b_sh    = b_q >> (int'(idx_q) * CHUNK);
  assign a_chunk = a_sh[CHUNK-1:0];
  assign b_chunk = b_sh[CHUNK-1:0];

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    rsp_valid_d = rsp_valid_q;
    less_d      = less_q;
    equal_d     = equal_q;
    taken_d     = taken_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          a_d     = rs1_data ^ sign_flip;
          b_d     = rs2_data ^ sign_flip;
          op_d    = br_op;
          idx_d   = IDX_W'(NCHUNK - 1);
          state_d = CMP;
          busy_d  = 1'b1;
        end
      end
      CMP: begin
        if (flush) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else if (a_chunk != b_chunk) begin
          less_d      = (a_chunk < b_chunk);
          equal_d     = 1'b0;
          taken_d     = taken_f(op_q, a_chunk < b_chunk, 1'b0);
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else if (idx_q == '0) begin
          less_d      = 1'b0;
          equal_d     = 1'b1;
          taken_d     = taken_f(op_q, 1'b0, 1'b1);
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      DONE: begin
        // Flush wins over a simultaneous consumer handshake; either way we drop to IDLE.
        if (flush || rsp_ready) begin
          rsp_valid_d = 1'b0;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      less_q      <= 1'b0;
      equal_q     <= 1'b0;
      taken_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      less_q      <= less_d;
      equal_q     <= equal_d;
      taken_q     <= taken_d;
      busy_q      <= busy_d;
    end
  end

  // Operand and opcode latches carry data only and need no reset.
  always_ff @(posedge i_clk) begin
    a_q  <= a_d;
    b_q  <= b_d;
    op_q <= op_d;
  end

  assign rsp_valid = rsp_valid_q;
  assign br_less   = less_q;
  assign br_equal  = equal_q;
  assign br_taken  = taken_q;
  assign busy      = busy_q;

endmodule
